reptile_core_p: RTL
===================

Name: reptile_core_p

Overview:
- Parametrised successor of the 16-bit Reptile multi-cycle accumulator-free CPU.
- Generalises data and address widths.
- Adds:
  - synchronous reset
  - memory ready handshake
  - carry flag and JC instruction
  - signed relative jumps
  - CALL/RET with a hardware return stack
  - HALT state on stack faults
- Sits between instruction/data memory (single shared port) and the board top, which displays reg0.

Parameters:
- DATA_W, 16: register and memory data width; must be >= 16 (instruction occupies data_in[15:0]).
- ADDR_W, 12: program counter and memory address width; must be >= 12.
- STACK_DEPTH, 4: return-stack entries; power of two, >= 2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- data_in  input  DATA_W  memory read data (instruction, immediate or load data).
- mem_ready  input  1  memory has completed the current access this cycle.
- data_out  output  DATA_W  store data = R[ir[8:6]].
- address  output  ADDR_W  memory address (combinational from state).
- memwt  output  1  write strobe, high while state==ST.
- reg0  output  DATA_W  R0 contents.
- halted  output  1  core in HALT.
- stack_err  output  1  sticky: overflow or underflow occurred.

Behaviour:
- Registers: 8 x DATA_W (R0..R7). Flags Z, C. PC[ADDR_W]. IR[12]. SP in 0..STACK_DEPTH.
- Reset (sync, rst=1 at posedge) applies from any state, including mid-access:
  - state=FETCH, PC=RESET_PC.
  - R0..R7=0, Z=C=0, SP=0.
  - halted=0, stack_err=0.
- Instruction fields:
  - opcode = data_in[15:12]; IR = data_in[11:0].
  - dst = IR[2:0], srcB = IR[5:3], srcA = IR[8:6], aluop = IR[11:9].
  - off = IR[11:0] sign-extended to ADDR_W.
- Memory stall rule: FETCH, LDI, LD and ST each hold state and all registers unchanged until mem_ready=1; the action below occurs on the edge where mem_ready=1.
- address:
  - LD or ST: R[srcB][ADDR_W-1:0]
  - all other states: PC
- FETCH:
  - Always: IR<=data_in[11:0]; PC<=PC+1 (wraps modulo 2^ADDR_W).
  - Next state by opcode:
    - 1: LDI
    - 2: LD
    - 3: ST
    - 4: JMP if Z else FETCH
    - 9: JMP if C else FETCH
    - 5: JMP
    - 6: CALL
    - 8: RET
    - 7: ALU
    - all others: FETCH (NOP)
- LDI: R[dst]<=data_in; PC<=PC+1; ->FETCH. Two words, 2 cycles minimum.
- LD: R[dst]<=data_in; ->FETCH.
- ST: memwt=1 for the cycle(s) in ST; ->FETCH.
- JMP: PC<=PC+off; PC already points past the instruction, so the target is instr_addr+1+off. ->FETCH.
- CALL:
  - SP<STACK_DEPTH: stack[SP]<=PC; SP<=SP+1; PC<=PC+off; ->FETCH.
  - SP==STACK_DEPTH: no push, PC unchanged; stack_err<=1; ->HALT.
- RET:
  - SP>0: PC<=stack[SP-1]; SP<=SP-1; ->FETCH.
  - SP==0: stack_err<=1; ->HALT.
- ALU: R[dst]<=result; Z<=(result==0); C updated as listed below, else unchanged; ->FETCH.
  - aluop 0: A+B, C=carry out.
  - aluop 1: A-B, C=borrow.
  - aluop 2: A&B.
  - aluop 3: A|B.
  - aluop 4: A^B.
  - aluop 5, sub-op srcA field, operand B:
    - 0: ~B (bitwise)
    - 1: B
    - 2: B+1, C=carry
    - 3: B-1, C=borrow
    - other sub-ops: result 0
  - aluop 6: B<<1, C=B[MSB].
  - aluop 7: B>>1 logical, C=B[0].
  - A=R[srcA], B=R[srcB]; all arithmetic is DATA_W wide.
- HALT: no register, PC, memory or flag change; memwt=0; address=PC; halted=1. Exits only via rst.
- Latency with mem_ready tied 1:
  - ALU, LD, ST, JMP, CALL, RET, taken JZ/JC: 2 cycles.
  - LDI: 2 cycles.
  - untaken JZ/JC and NOP: 1 cycle.

Test Plan:
- Reset/LDI/ALU:
  - Stimulus: mem_ready=1; program LDI R1,0x0005; LDI R2,0x0003; ADD R0=R1+R2.
  - Required: reg0=0x0008, Z=0, C=0.
  - Then assert rst mid-ALU: reg0=0, PC=RESET_PC next cycle.
- Carry and JC:
  - Stimulus: R1=0xFFFF, R2=0x0001, ADD R3; JC +2.
  - Required: R3=0x0000, Z=1, C=1; PC skips two words.
  - Also DEC of 0x0000 gives 0xFFFF with C=1.
- Signed jump:
  - Stimulus: JMP at address 0x010 with off=0xFFE.
  - Required: next fetch address 0x00F.
  - Also JZ with Z=0 falls through in 1 cycle.
- Memory stall:
  - Stimulus: mem_ready low for 3 cycles during ST of R2=0xABCD to address R1=0x040.
  - Required: memwt, address=0x040 and data_out=0xABCD held steady 4 cycles; no PC change until ready.
- Call/return nesting:
  - Stimulus: STACK_DEPTH=4, four nested CALLs then four RETs.
  - Required: return addresses popped in LIFO order, stack_err=0.
  - A fifth CALL: halted=1, stack_err=1, PC frozen.
- Underflow:
  - Stimulus: RET with SP=0.
  - Required: halted=1, stack_err=1 sticky.
  - Then rst: halted=0, stack_err=0, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/reptile_mem_if.sv
// Shared instruction/data memory port of the Reptile core: one address,
// read data with a ready handshake, and write data with a write strobe.
interface reptile_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic [DATA_W-1:0] data_in;
  logic              mem_ready;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] address;
  logic              memwt;

  modport master (input data_in, mem_ready, output data_out, address, memwt);
  modport slave  (output data_in, mem_ready, input data_out, address, memwt);
endinterface

// File: rtl/reptile_core_p.sv
// Parametrised multi-cycle Reptile CPU: 8 registers, Z/C flags, relative
// jumps, CALL/RET through a small hardware return stack, HALT on stack faults.
module reptile_core_p #(
  parameter int          DATA_W      = 16,
  parameter int          ADDR_W      = 12,
  parameter int          STACK_DEPTH = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic              clk,
  input  logic              rst,
  reptile_mem_if.master     mem,
  output logic [DATA_W-1:0] reg0,
  output logic              halted,
  output logic              stack_err
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  typedef enum logic [3:0] {
    S_FETCH, S_LDI, S_LD, S_ST, S_JMP, S_CALL, S_RET, S_ALU, S_HALT
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [11:0]       ir_reg, ir_next;
  logic              z_reg, z_next, c_reg, c_next;
  logic [SP_W-1:0]   sp_reg, sp_next, sp_dec;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] rf [8];
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic              rf_we, push_en;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] op_a, op_b, alu_res;
  logic [DATA_W:0]   alu_wide;
  logic              alu_c_upd;
  logic [ADDR_W-1:0] off;

  assign op_a   = rf[ir_reg[8:6]];
  assign op_b   = rf[ir_reg[5:3]];
  assign off    = ADDR_W'(signed'(ir_reg));
  assign sp_dec = sp_reg - SP_W'(1);

  assign mem.address  = (state_reg == S_LD || state_reg == S_ST) ? ADDR_W'(op_b) : pc_reg;
  assign mem.memwt    = (state_reg == S_ST);
  assign mem.data_out = op_a;
  assign reg0         = rf[0];
  assign halted       = (state_reg == S_HALT);
  assign stack_err    = err_reg;

  // Bit DATA_W of alu_wide carries the carry/borrow/shifted-out bit.
  always_comb begin
    alu_wide  = '0;
    alu_c_upd = 1'b0;
    case (ir_reg[11:9])
      3'd0: begin alu_wide = {1'b0, op_a} + {1'b0, op_b}; alu_c_upd = 1'b1; end
      3'd1: begin alu_wide = {1'b0, op_a} - {1'b0, op_b}; alu_c_upd = 1'b1; end
      3'd2: alu_wide = {1'b0, op_a & op_b};
      3'd3: alu_wide = {1'b0, op_a | op_b};
      3'd4: alu_wide = {1'b0, op_a ^ op_b};
      3'd5: begin
        case (ir_reg[8:6])
          3'd0: alu_wide = {1'b0, ~op_b};
          3'd1: alu_wide = {1'b0, op_b};
          3'd2: begin alu_wide = {1'b0, op_b} + (DATA_W+1)'(1); alu_c_upd = 1'b1; end
          3'd3: begin alu_wide = {1'b0, op_b} - (DATA_W+1)'(1); alu_c_upd = 1'b1; end
          default: alu_wide = '0;
        endcase
      end
      3'd6: begin alu_wide = {op_b, 1'b0}; alu_c_upd = 1'b1; end
      default: begin alu_wide = {op_b[0], 1'b0, op_b[DATA_W-1:1]}; alu_c_upd = 1'b1; end
    endcase
  end
  assign alu_res = alu_wide[DATA_W-1:0];

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    z_next     = z_reg;
    c_next     = c_reg;
    sp_next    = sp_reg;
    err_next   = err_reg;
    rf_we      = 1'b0;
    rf_wdata   = mem.data_in;
    push_en    = 1'b0;
    case (state_reg)
      S_FETCH: if (mem.mem_ready) begin
        ir_next = mem.data_in[11:0];
        pc_next = pc_reg + ADDR_W'(1);
        case (mem.data_in[15:12])
          4'd1: state_next = S_LDI;
          4'd2: state_next = S_LD;
          4'd3: state_next = S_ST;
          4'd4: state_next = z_reg ? S_JMP : S_FETCH;
          4'd9: state_next = c_reg ? S_JMP : S_FETCH;
          4'd5: state_next = S_JMP;
          4'd6: state_next = S_CALL;
          4'd8: state_next = S_RET;
          4'd7: state_next = S_ALU;
          default: state_next = S_FETCH;
        endcase
      end
      S_LDI: if (mem.mem_ready) begin
        rf_we      = 1'b1;
        pc_next    = pc_reg + ADDR_W'(1);
        state_next = S_FETCH;
      end
      S_LD: if (mem.mem_ready) begin
        rf_we      = 1'b1;
        state_next = S_FETCH;
      end
      S_ST: if (mem.mem_ready) state_next = S_FETCH;
      S_JMP: begin
        pc_next    = pc_reg + off;
        state_next = S_FETCH;
      end
      S_CALL: begin
        if (sp_reg < SP_W'(STACK_DEPTH)) begin
          push_en    = 1'b1;
          sp_next    = sp_reg + SP_W'(1);
          pc_next    = pc_reg + off;
          state_next = S_FETCH;
        end else begin
          err_next   = 1'b1;
          state_next = S_HALT;
        end
      end
      S_RET: begin
        if (sp_reg != '0) begin
          pc_next    = stack_mem[sp_dec[SP_W-2:0]];
          sp_next    = sp_dec;
          state_next = S_FETCH;
        end else begin
          err_next   = 1'b1;
          state_next = S_HALT;
        end
      end
      S_ALU: begin
        rf_we      = 1'b1;
        rf_wdata   = alu_res;
        z_next     = (alu_res == '0);
        c_next     = alu_c_upd ? alu_wide[DATA_W] : c_reg;
        state_next = S_FETCH;
      end
      default: state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      pc_reg    <= ADDR_W'(RESET_PC);
      ir_reg    <= '0;
      z_reg     <= 1'b0;
      c_reg     <= 1'b0;
      sp_reg    <= '0;
      err_reg   <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      z_reg     <= z_next;
      c_reg     <= c_next;
      sp_reg    <= sp_next;
      err_reg   <= err_next;
      if (rf_we) rf[ir_reg[2:0]] <= rf_wdata;
    end
  end

  // Return stack is plain storage; only SP needs clearing on reset.
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[sp_reg[SP_W-2:0]] <= pc_reg;
  end
endmodule
